enemy_anim_sequencer: RTL and testbench

Per-enemy animation and motion controller for the running-enemy sprites. Sequences the four running-frame sprite mappers (L1–L4), steps the enemy's horizontal position, and runs the hit/death sequence. Its outputs select which frame mapper drives the pixel mux and where it is placed. All visible updates land on frame boundaries so a sprite never tears mid-scan.

---
 rtl/contra_sprite_pkg.sv | 13 +
 rtl/anim_step_div.sv | 41 ++++
 rtl/enemy_anim_sequencer.sv | 173 +++++++++++++++++
 tb/tb_enemy_anim_sequencer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/contra_sprite_pkg.sv
// Shared types and constants for the contra sprite sequencers.
package contra_sprite_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDie
  } enemy_state_t;

  localparam int unsigned NUM_RUN_FRAMES = 4;
  localparam int unsigned ANIM_FRAME_W   = $clog2(NUM_RUN_FRAMES);

endpackage

// File: rtl/anim_step_div.sv
// Divides frame_tick down to one step pulse every FRAMES_PER_STEP ticks.
// clear restarts the count and suppresses the step on that cycle.
module anim_step_div #(
  parameter int unsigned FRAMES_PER_STEP = 6
) (
  input  logic vga_clk,
  input  logic reset_n,
  input  logic tick,
  input  logic clear,
  output logic step
);

  localparam int unsigned CntW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(FRAMES_PER_STEP - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    step  = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (tick) begin
      if (cnt_q == CntMax) begin
        cnt_d = '0;
        step  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/enemy_anim_sequencer.sv
// Running-enemy animation/motion controller; all updates land on frame_tick.
// Optional ENEMY_DIE_BLINK_EN: visible blinks during the death sequence.
module enemy_anim_sequencer
  import contra_sprite_pkg::*;
#(
  parameter int unsigned FRAMES_PER_STEP = 6,
  parameter int unsigned DIE_STEPS       = 8,
  parameter int unsigned SPEED           = 2,
  parameter int unsigned X_W             = 10,
  parameter int unsigned X_MIN           = 0,
  parameter int unsigned X_MAX           = 600
) (
  input  logic                    vga_clk,
  input  logic                    reset_n,
  input  logic                    frame_tick,
  input  logic                    spawn,
  input  logic [X_W-1:0]          spawn_x,
  input  logic                    spawn_left,
  input  logic                    hit,
  output logic [X_W-1:0]          sprite_x,
  output logic [ANIM_FRAME_W-1:0] anim_frame,
  output logic                    visible,
  output logic                    flip_x,
  output logic                    dying,
  output logic                    busy
);

  localparam int unsigned XW1     = X_W + 1;
  localparam int unsigned DieCntW = (DIE_STEPS > 1) ? $clog2(DIE_STEPS) : 1;
  localparam logic [X_W:0] SpeedExt = XW1'(SPEED);
  localparam logic [X_W:0] XMinExt  = XW1'(X_MIN);
  localparam logic [X_W:0] XMaxExt  = XW1'(X_MAX);
  localparam logic [DieCntW-1:0] DieLast = DieCntW'(DIE_STEPS - 1);

  enemy_state_t            state_q, state_d;
  logic [X_W-1:0]          x_q, x_d;
  logic [ANIM_FRAME_W-1:0] frame_q, frame_d;
  logic                    flip_q, flip_d;
  logic                    vis_q, vis_d;
  logic [DieCntW-1:0]      die_cnt_q, die_cnt_d;
  logic                    spawn_pend_q, spawn_pend_d;
  logic                    hit_pend_q, hit_pend_d;
  logic [X_W-1:0]          spawn_x_q, spawn_x_d;
  logic                    spawn_left_q, spawn_left_d;

  logic           spawn_now, hit_now, sel_left;
  logic [X_W-1:0] sel_x;
  logic [X_W:0]   nx_left, nx_right;
  logic           out_of_range;
  logic           div_tick, div_clear, step;

  anim_step_div #(
    .FRAMES_PER_STEP(FRAMES_PER_STEP)
  ) u_step_div (
    .vga_clk(vga_clk),
    .reset_n(reset_n),
    .tick   (div_tick),
    .clear  (div_clear),
    .step   (step)
  );

  assign div_tick = frame_tick && (state_q != StIdle);

  // A request arriving on the tick cycle itself is consumed by that tick.
  assign spawn_now = spawn_pend_q | spawn;
  assign hit_now   = hit_pend_q | hit;
  assign sel_x     = spawn ? spawn_x : spawn_x_q;
  assign sel_left  = spawn ? spawn_left : spawn_left_q;

  // Left move is evaluated as signed so an underflow reads as negative.
  assign nx_left  = {1'b0, x_q} - SpeedExt;
  assign nx_right = {1'b0, x_q} + SpeedExt;
  assign out_of_range = flip_q ? (nx_right > XMaxExt)
                               : (($signed(nx_left) < $signed(XMinExt)) ||
                                  ($signed(nx_left) > $signed(XMaxExt)));

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    frame_d      = frame_q;
    flip_d       = flip_q;
    vis_d        = vis_q;
    die_cnt_d    = die_cnt_q;
    div_clear    = 1'b0;
    spawn_pend_d = spawn_now;
    hit_pend_d   = hit_now;
    spawn_x_d    = sel_x;
    spawn_left_d = sel_left;

    if (frame_tick) begin
      spawn_pend_d = 1'b0;
      hit_pend_d   = 1'b0;
      unique case (state_q)
        StIdle: begin
          if (spawn_now) begin
            state_d   = StRun;
            x_d       = sel_x;
            flip_d    = ~sel_left;
            frame_d   = '0;
            vis_d     = 1'b1;
            div_clear = 1'b1;
          end
        end
        StRun: begin
          if (hit_now) begin
            state_d   = StDie;
            die_cnt_d = '0;
            div_clear = 1'b1;
`ifdef ENEMY_DIE_BLINK_EN
            vis_d     = 1'b0;
`else
            vis_d     = 1'b1;
`endif
          end else if (out_of_range) begin
            state_d = StIdle;
            vis_d   = 1'b0;
          end else begin
            x_d = flip_q ? nx_right[X_W-1:0] : nx_left[X_W-1:0];
            if (step) frame_d = frame_q + 1'b1;
          end
        end
        StDie: begin
`ifdef ENEMY_DIE_BLINK_EN
          vis_d = ~vis_q;
`endif
          if (step) begin
            if (die_cnt_q == DieLast) begin
              state_d = StIdle;
              vis_d   = 1'b0;
            end else begin
              die_cnt_d = die_cnt_q + 1'b1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      x_q          <= '0;
      frame_q      <= '0;
      flip_q       <= 1'b0;
      vis_q        <= 1'b0;
      die_cnt_q    <= '0;
      spawn_pend_q <= 1'b0;
      hit_pend_q   <= 1'b0;
      spawn_x_q    <= '0;
      spawn_left_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      frame_q      <= frame_d;
      flip_q       <= flip_d;
      vis_q        <= vis_d;
      die_cnt_q    <= die_cnt_d;
      spawn_pend_q <= spawn_pend_d;
      hit_pend_q   <= hit_pend_d;
      spawn_x_q    <= spawn_x_d;
      spawn_left_q <= spawn_left_d;
    end
  end

  assign sprite_x   = x_q;
  assign anim_frame = frame_q;
  assign visible    = vis_q;
  assign flip_x     = flip_q;
  assign dying      = (state_q == StDie);
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_enemy_anim_sequencer.sv
// Randomized bench for enemy_anim_sequencer against a tick-count reference model.
module tb_enemy_anim_sequencer;

  localparam int FPS   = 6;
  localparam int DSTEP = 8;
  localparam int SPD   = 2;
  localparam int XW    = 10;
  localparam int XMIN  = 0;
  localparam int XMAX  = 600;
`ifdef ENEMY_DIE_BLINK_EN
  localparam bit Blink = 1'b1;
`else
  localparam bit Blink = 1'b0;
`endif

  logic          vga_clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          frame_tick = 1'b0;
  logic          spawn = 1'b0;
  logic [XW-1:0] spawn_x = '0;
  logic          spawn_left = 1'b0;
  logic          hit = 1'b0;
  logic [XW-1:0] sprite_x;
  logic [1:0]    anim_frame;
  logic          visible, flip_x, dying, busy;

  int errors = 0;
  int checks = 0;

  enemy_anim_sequencer dut (
    .vga_clk   (vga_clk),
    .reset_n   (reset_n),
    .frame_tick(frame_tick),
    .spawn     (spawn),
    .spawn_x   (spawn_x),
    .spawn_left(spawn_left),
    .hit       (hit),
    .sprite_x  (sprite_x),
    .anim_frame(anim_frame),
    .visible   (visible),
    .flip_x    (flip_x),
    .dying     (dying),
    .busy      (busy)
  );

  always #5 vga_clk = ~vga_clk;

  // Reference model: state 0 idle, 1 run, 2 die; frame derived from moves made.
  int m_state, m_x, m_flip, m_frame, m_run_ticks, m_die_ticks, m_sx;
  bit m_sl, m_sp_pend, m_hit_pend;

  function automatic void model_reset();
    m_state = 0; m_x = 0; m_flip = 0; m_frame = 0;
    m_run_ticks = 0; m_die_ticks = 0; m_sx = 0; m_sl = 0;
    m_sp_pend = 0; m_hit_pend = 0;
  endfunction

  function automatic void model_cycle(bit tk, bit sp, int sx, bit sl, bit h);
    bit sp_now, h_now;
    int n;
    sp_now = m_sp_pend | sp;
    h_now  = m_hit_pend | h;
    if (sp) begin m_sx = sx; m_sl = sl; end
    if (!tk) begin
      m_sp_pend = sp_now; m_hit_pend = h_now;
      return;
    end
    m_sp_pend = 0; m_hit_pend = 0;
    case (m_state)
      0: if (sp_now) begin
        m_state = 1; m_x = m_sx; m_flip = !m_sl; m_run_ticks = 0; m_frame = 0;
      end
      1: if (h_now) begin
        m_state = 2; m_die_ticks = 0;
      end else begin
        n = m_x + (m_flip != 0 ? SPD : -SPD);
        if (n < XMIN || n > XMAX) m_state = 0;
        else begin
          m_x = n;
          m_run_ticks++;
          m_frame = (m_run_ticks / FPS) % 4;
        end
      end
      default: begin
        m_die_ticks++;
        if (m_die_ticks == DSTEP * FPS) m_state = 0;
      end
    endcase
  endfunction

  function automatic int exp_vis();
    if (m_state == 1) return 1;
    if (m_state == 2) return Blink ? (m_die_ticks % 2) : 1;
    return 0;
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    check("sprite_x", 32'(sprite_x), m_x);
    check("anim_frame", 32'(anim_frame), m_frame);
    check("visible", 32'(visible), exp_vis());
    check("flip_x", 32'(flip_x), m_flip);
    check("dying", 32'(dying), (m_state == 2) ? 1 : 0);
    check("busy", 32'(busy), (m_state != 0) ? 1 : 0);
  endtask

  task automatic cyc(bit tk, bit sp, int sx, bit sl, bit h);
    frame_tick = tk; spawn = sp; spawn_x = sx[XW-1:0]; spawn_left = sl; hit = h;
    @(posedge vga_clk);
    model_cycle(tk, sp, sx, sl, h);
    #1;
    frame_tick = 0; spawn = 0; hit = 0;
    check_all();
  endtask

  task automatic tick(int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge vga_clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #2;
    check_all();
    @(posedge vga_clk);
    #1;
    reset_n = 1'b1;

    // Idle ticks with no requests.
    tick(10);
    check("idle_busy", 32'(busy), 0);

    // Spawn at 300 moving left, then six more ticks.
    cyc(0, 1, 300, 1, 0);
    tick(1);
    check("spawn_x", 32'(sprite_x), 300);
    check("spawn_flip", 32'(flip_x), 0);
    check("spawn_vis", 32'(visible), 1);
    tick(6);
    check("step_x", 32'(sprite_x), 288);
    check("step_frame", 32'(anim_frame), 1);

    // Left bound exit.
    do_reset();
    cyc(0, 1, 3, 1, 0);
    tick(2);
    check("edge_x", 32'(sprite_x), 1);
    tick(1);
    check("edge_vis", 32'(visible), 0);
    check("edge_busy", 32'(busy), 0);
    check("edge_hold", 32'(sprite_x), 1);

    // Hit at frame 2, death lasts 48 ticks; a hit during DIE is ignored.
    do_reset();
    cyc(0, 1, 300, 1, 0);
    tick(13);
    check("pre_hit_frame", 32'(anim_frame), 2);
    cyc(0, 0, 0, 0, 1);
    tick(1);
    check("die_dying", 32'(dying), 1);
    check("die_frame", 32'(anim_frame), 2);
    check("die_x", 32'(sprite_x), 276);
    tick(10);
    cyc(0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    tick(36);
    check("die_busy47", 32'(busy), 1);
    tick(1);
    check("die_busy48", 32'(busy), 0);

    // Spawn and hit together while idle: run, no death.
    do_reset();
    cyc(0, 1, 100, 0, 1);
    tick(1);
    check("sh_busy", 32'(busy), 1);
    check("sh_dying", 32'(dying), 0);
    tick(3);

    // Reset pulse mid-DIE.
    cyc(1, 0, 0, 0, 1);
    tick(5);
    do_reset();
    check("rst_dying", 32'(dying), 0);
    tick(3);

    // Randomized phase.
    for (int i = 0; i < 4000; i++) begin
      bit tk, sp, sl, h;
      int sx;
      tk = ($urandom_range(0, 99) < 45);
      sp = ($urandom_range(0, 14) == 0);
      h  = ($urandom_range(0, 59) == 0);
      sl = $urandom_range(0, 1);
      sx = ($urandom_range(0, 3) == 0) ?
           ($urandom_range(0, 1) ? $urandom_range(0, 4) : $urandom_range(596, 600)) :
           $urandom_range(0, 600);
      if ($urandom_range(0, 999) == 0) do_reset();
      else cyc(tk, sp, sx, sl, h);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
